// File: rtl/id_stage.sv
// Decode / operand-fetch stage feeding ex: decodes the instruction class, reads a bypassed
// 16-entry register file, stalls one cycle on a RAW hazard and registers the bundle for ex.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_v_i,
    input  logic [31:0]       inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              ready_o,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              v_o,
    output logic [DATA_W-1:0] rd_value_o,
    output logic [DATA_W-1:0] rs_value_o,
    output logic [DATA_W-1:0] imm_value_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [PC_W-1:0]   pc_value_o,
    output logic [6:0]        opcode_o,
    output logic              ctrl_inte_o,
    output logic              ctrl_logic_o,
    output logic              ctrl_shift_o,
    output logic              ctrl_ld_o,
    output logic              ctrl_st_o,
    output logic              ctrl_br_o,
    output logic              immf_o,
    output logic              rsv_o
);

    // Handshake: an instruction is taken from fetch on a rising edge where inst_v_i && ready_o;
    // when branch_taken_i is high that taken instruction is discarded instead of issued.

    logic [ADDR_W-1:0] dec_rd;
    logic [ADDR_W-1:0] dec_rs;
    logic              dec_immf;
    logic [DATA_W-1:0] dec_imm;
    logic              d_inte, d_logic, d_shift, d_ld, d_st, d_br, d_rsv;
    logic [DATA_W-1:0] rd_read, rs_read;
    logic              haz;
    logic              clear;

    logic [DATA_W-1:0] regs [2**ADDR_W];

    assign dec_rd   = inst_i[21 +: ADDR_W];
    assign dec_rs   = inst_i[17 +: ADDR_W];
    assign dec_immf = inst_i[16];
    assign dec_imm  = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};

    always_comb begin
        d_inte  = 1'b0;
        d_logic = 1'b0;
        d_shift = 1'b0;
        d_ld    = 1'b0;
        d_st    = 1'b0;
        d_br    = 1'b0;
        case (inst_i[31:29])
            3'b000:  d_inte  = 1'b1;
            3'b001:  d_logic = 1'b1;
            3'b010:  d_shift = 1'b1;
            3'b011:  d_ld    = 1'b1;
            3'b100:  d_st    = 1'b1;
            3'b101:  d_br    = 1'b1;
            default: ;
        endcase
        d_rsv = d_inte | d_logic | d_shift | d_ld;
    end

    // Write-through: a read of the address being written this cycle sees the new data.
    assign rd_read = (wb_en_i && wb_addr_i == dec_rd) ? wb_data_i : regs[dec_rd];
    assign rs_read = (wb_en_i && wb_addr_i == dec_rs) ? wb_data_i : regs[dec_rs];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (wb_en_i) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Only a result-producing instruction in ex can conflict; an immediate op ignores rs.
    assign haz = v_o & rsv_o & inst_v_i &
                 ((rd_addr_o == dec_rd) | (!dec_immf & (rd_addr_o == dec_rs)));

    assign ready_o = branch_taken_i | (!stall_i & !haz);

    assign clear = rst | branch_taken_i | (!stall_i & (haz | !inst_v_i));

    always_ff @(posedge clk) begin
        if (clear) begin
            v_o          <= 1'b0;
            rd_value_o   <= '0;
            rs_value_o   <= '0;
            imm_value_o  <= '0;
            rd_addr_o    <= '0;
            pc_value_o   <= '0;
            opcode_o     <= '0;
            ctrl_inte_o  <= 1'b0;
            ctrl_logic_o <= 1'b0;
            ctrl_shift_o <= 1'b0;
            ctrl_ld_o    <= 1'b0;
            ctrl_st_o    <= 1'b0;
            ctrl_br_o    <= 1'b0;
            immf_o       <= 1'b0;
            rsv_o        <= 1'b0;
        end else if (!stall_i) begin
            v_o          <= 1'b1;
            rd_value_o   <= rd_read;
            rs_value_o   <= rs_read;
            imm_value_o  <= dec_imm;
            rd_addr_o    <= dec_rd;
            pc_value_o   <= pc_i;
            opcode_o     <= inst_i[31:25];
            ctrl_inte_o  <= d_inte;
            ctrl_logic_o <= d_logic;
            ctrl_shift_o <= d_shift;
            ctrl_ld_o    <= d_ld;
            ctrl_st_o    <= d_st;
            ctrl_br_o    <= d_br;
            immf_o       <= dec_immf;
            rsv_o        <= d_rsv;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random traffic, every cycle compared
// against a behavioural model of the stage's issue/stall/flush rules and register file.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, inst_v_i, stall_i, branch_taken_i, wb_en_i;
    logic [31:0] inst_i, wb_data_i;
    logic [15:0] pc_i;
    logic [3:0]  wb_addr_i;
    logic        ready_o, v_o;
    logic [31:0] rd_value_o, rs_value_o, imm_value_o;
    logic [3:0]  rd_addr_o;
    logic [15:0] pc_value_o;
    logic [6:0]  opcode_o;
    logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
    logic        immf_o, rsv_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .inst_v_i(inst_v_i), .inst_i(inst_i), .pc_i(pc_i),
        .ready_o(ready_o), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .v_o(v_o), .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
        .imm_value_o(imm_value_o), .rd_addr_o(rd_addr_o), .pc_value_o(pc_value_o),
        .opcode_o(opcode_o), .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o),
        .ctrl_shift_o(ctrl_shift_o), .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o),
        .ctrl_br_o(ctrl_br_o), .immf_o(immf_o), .rsv_o(rsv_o)
    );

    typedef struct {
        logic        v;
        logic [31:0] rd_val, rs_val, imm;
        logic [3:0]  rd_addr;
        logic [15:0] pc;
        logic [6:0]  opcode;
        logic [5:0]  cls;   // one-hot: inte, logic, shift, ld, st, br
        logic        immf, rsv;
    } bundle_t;

    bundle_t     exp_b;
    bundle_t     empty_b;
    logic [31:0] mregs [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                       input int immf, input int imm);
        logic [6:0]  o = op[6:0];
        logic [3:0]  d = rd[3:0];
        logic [3:0]  s = rs[3:0];
        logic [15:0] i = imm[15:0];
        return {o, d, s, immf[0], i};
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (wb_en_i && wb_addr_i == a) return wb_data_i;
        return mregs[a];
    endfunction

    function automatic logic model_conflict();
        int rd = int'(inst_i[24:21]);
        int rs = int'(inst_i[20:17]);
        if (!(exp_b.v && exp_b.rsv && inst_v_i)) return 1'b0;
        return (int'(exp_b.rd_addr) == rd) || (!inst_i[16] && int'(exp_b.rd_addr) == rs);
    endfunction

    function automatic bundle_t model_decode();
        bundle_t b;
        int grp = int'(inst_i[31:29]);
        b.v       = 1'b1;
        b.rd_val  = model_read(inst_i[24:21]);
        b.rs_val  = model_read(inst_i[20:17]);
        b.imm     = 32'(signed'(inst_i[15:0]));
        b.rd_addr = inst_i[24:21];
        b.pc      = pc_i;
        b.opcode  = inst_i[31:25];
        b.cls     = (grp < 6) ? 6'(1 << grp) : 6'd0;
        b.immf    = inst_i[16];
        b.rsv     = (grp < 4);
        return b;
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, ".v"},      32'(v_o),         32'(exp_b.v));
        check({tag, ".rd_val"}, rd_value_o,       exp_b.rd_val);
        check({tag, ".rs_val"}, rs_value_o,       exp_b.rs_val);
        check({tag, ".imm"},    imm_value_o,      exp_b.imm);
        check({tag, ".rd"},     32'(rd_addr_o),   32'(exp_b.rd_addr));
        check({tag, ".pc"},     32'(pc_value_o),  32'(exp_b.pc));
        check({tag, ".op"},     32'(opcode_o),    32'(exp_b.opcode));
        check({tag, ".cls"},    32'({ctrl_br_o, ctrl_st_o, ctrl_ld_o, ctrl_shift_o,
                                     ctrl_logic_o, ctrl_inte_o}), 32'(exp_b.cls));
        check({tag, ".immf"},   32'(immf_o),      32'(exp_b.immf));
        check({tag, ".rsv"},    32'(rsv_o),       32'(exp_b.rsv));
    endtask

    // Drive one cycle of inputs, check ready_o, advance the model across the edge, compare.
    task automatic step(input string tag, input logic r, input logic iv, input logic [31:0] ins,
                        input logic [15:0] pc, input logic st, input logic br,
                        input logic we, input logic [3:0] wa, input logic [31:0] wd);
        bundle_t nxt;
        logic    exp_ready;
        rst = r; inst_v_i = iv; inst_i = ins; pc_i = pc; stall_i = st; branch_taken_i = br;
        wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
        #1;
        exp_ready = br || (!st && !model_conflict());
        check({tag, ".ready"}, 32'(ready_o), 32'(exp_ready));
        if (r || br)                  nxt = empty_b;
        else if (st)                  nxt = exp_b;
        else if (model_conflict())    nxt = empty_b;
        else if (iv)                  nxt = model_decode();
        else                          nxt = empty_b;
        if (r) foreach (mregs[i]) mregs[i] = '0;
        else if (we) mregs[wa] = wd;
        @(posedge clk);
        #1;
        exp_b = nxt;
        compare_outputs(tag);
    endtask

    logic [31:0] held_rd;
    logic [31:0] held_rs;
    logic [31:0] ins_a;
    logic [31:0] ins_b;
    logic [31:0] ri;
    logic [31:0] rw;

    initial begin
        empty_b = '{v: 1'b0, rd_val: '0, rs_val: '0, imm: '0, rd_addr: '0, pc: '0,
                    opcode: '0, cls: '0, immf: 1'b0, rsv: 1'b0};
        exp_b = empty_b;
        foreach (mregs[i]) mregs[i] = '0;
        rst = 1'b1; inst_v_i = 1'b0; inst_i = '0; pc_i = '0; stall_i = 1'b0;
        branch_taken_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        @(negedge clk);

        // Reset state
        step("reset", 1, 0, 0, 0, 0, 0, 1, 4'd9, 32'h1234);
        check("reset.v_const", 32'(v_o), 0);

        // Operands written back, then read by an add
        step("wb_r1", 0, 0, 0, 0, 0, 0, 1, 4'd1, 32'd5);
        step("wb_r2", 0, 0, 0, 0, 0, 0, 1, 4'd2, 32'd7);
        step("add", 0, 1, mk(7'h00, 1, 2, 0, 0), 16'h0010, 0, 0, 0, 0, 0);
        check("add.rd_const", rd_value_o, 32'd5);
        check("add.rs_const", rs_value_o, 32'd7);
        check("add.inte_const", 32'(ctrl_inte_o), 1);
        check("add.rsv_const", 32'(rsv_o), 1);

        // Same-cycle write-back bypass
        step("bypass", 0, 1, mk(7'h10, 6, 3, 0, 0), 16'h0014, 0, 0, 1, 4'd3, 32'hDEADBEEF);
        check("bypass.rs_const", rs_value_o, 32'hDEADBEEF);

        // Dependent back-to-back pair costs one bubble
        step("dep_a", 0, 1, mk(7'h01, 4, 5, 0, 0), 16'h0018, 0, 0, 0, 0, 0);
        ins_b = mk(7'h02, 5, 4, 0, 0);
        step("dep_b_stall", 0, 1, ins_b, 16'h001C, 0, 0, 1, 4'd4, 32'h44);
        check("dep.bubble_v", 32'(v_o), 0);
        check("dep.bubble_inte", 32'(ctrl_inte_o), 0);
        step("dep_b_issue", 0, 1, ins_b, 16'h001C, 0, 0, 0, 0, 0);
        check("dep.issue_v", 32'(v_o), 1);
        check("dep.issue_rs", rs_value_o, 32'h44);

        // Immediate form ignores rs conflict; negative imm sign-extends
        step("imm", 0, 1, mk(7'h20, 8, 5, 1, 16'h8000), 16'h0020, 0, 0, 0, 0, 0);
        check("imm.v", 32'(v_o), 1);
        check("imm.value_const", imm_value_o, 32'hFFFF8000);

        // Stall holds the bundle even while the register file changes
        held_rd = rd_value_o;
        held_rs = rs_value_o;
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 1, mk(7'h30, 9, 8, 0, 0), 16'h0024, 1, 0, 1, 4'd8, 32'(i + 100));
            check("stall.ready_const", 32'(ready_o), 0);
            check("stall.rd_held", rd_value_o, held_rd);
            check("stall.rs_held", rs_value_o, held_rs);
        end
        step("stall_flush", 0, 1, mk(7'h30, 9, 8, 0, 0), 16'h0024, 1, 1, 0, 0, 0);
        check("stall_flush.v", 32'(v_o), 0);

        // Reset mid-stream clears outputs and register file
        ins_a = mk(7'h50, 1, 2, 0, 0);
        step("pre_rst", 0, 1, ins_a, 16'h0030, 0, 0, 0, 0, 0);
        check("pre_rst.v", 32'(v_o), 1);
        step("mid_rst", 1, 1, ins_a, 16'h0034, 0, 0, 1, 4'd1, 32'h77);
        step("post_rst", 0, 1, mk(7'h70, 1, 2, 0, 0), 16'h0038, 0, 0, 0, 0, 0);
        check("post_rst.rd_zero", rd_value_o, 0);
        check("post_rst.rs_zero", rs_value_o, 0);
        check("post_rst.nop_v", 32'(v_o), 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            rw = $urandom;
            step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 {ri[31:25], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ri[16:0]},
                 16'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), rw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
